dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory controller between the CPU load/store unit and the 16-bit asynchronous-SRAM-style `dmem` array. It accepts one 32-bit byte/half/word load or store at a time and sequences it into one or two 16-bit SRAM cycles. Each cycle drives the active-low chip, write, output and byte-lane enables, and the bidirectional data bus. Load data returns aligned and sign- or zero-extended to the CPU.

## Interface
Parameters:
- `ADDR_W`, 20: SRAM byte-address width. Bit 0 is always driven 0; the SRAM indexes halfwords.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle; the request is accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word. The value 11 is treated as word.
- `req_unsigned` in 1: zero-extend a load (LBU/LHU).
- `req_addr` in 32: byte address. Bits [31:ADDR_W] are ignored.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle pulse. Load data or store completion is valid.
- `resp_rdata` out 32: extended load data. Value is 0 for stores.
- `resp_err` out 1: misaligned access; qualified by `resp_valid`.
- `sram_ce_n`, `sram_we_n`, `sram_oe_n`, `sram_lb_n`, `sram_ub_n` out 1 each: active-low SRAM controls.
  - LB selects `dq[7:0]`, the even byte.
  - UB selects `dq[15:8]`, the odd byte.
- `sram_addr` out ADDR_W: SRAM byte address, always even.
- `sram_dq` inout 16: driven only during write cycles; high-Z otherwise.

## Operation
FSM states are IDLE, ACC_LO, ACC_HI, RESP.

- **IDLE:** `req_ready`=1.
  - On accept, latch the request and go to ACC_LO.
  - A misaligned request goes to RESP with error (see Configuration).
- **ACC_LO:** `sram_ce_n`=0 and `sram_addr`={addr[ADDR_W-1:1],0}.
  - **Load:** `oe_n`=0, `we_n`=1, `dq`=Z. The addressed lanes are selected; on the closing edge, capture `dq` into a 32-bit buffer, low half.
  - **Store:** `we_n`=0, `oe_n`=1.
    - Byte store: `dq`={b,b}. `lb_n`=addr[0], `ub_n`=~addr[0].
    - Half and word stores: `dq`=wdata[15:0] with both lanes enabled.
  - Word goes to ACC_HI; otherwise RESP.
- **ACC_HI:** word accesses only. `sram_addr`=+2 and both lanes are enabled.
  - Load: capture `dq` into buffer[31:16].
  - Store: drive wdata[31:16].
  - Then go to RESP.
- **RESP:** `resp_valid`=1 and all SRAM controls are deasserted. Then go to IDLE.
- **Load extension:**
  - Byte: `dq[7:0]` if addr[0]=0, else `dq[15:8]`.
  - Sign-extend from bit 7 (byte) or bit 15 (half) unless `req_unsigned`.
  - Word loads are not extended.
- **Stores and errors:** `resp_rdata`=0 for stores. `resp_err`=1 on a misaligned request, with no SRAM cycle issued.
- **No backpressure:** the CPU must sink `resp_valid` in the cycle it is asserted.
- **Inputs while busy:** `req_*` are ignored outside IDLE.

## Timing
- **Reset values** (cycle after the `rst_n`=0 edge):
  - `req_ready`=0 while `rst_n`=0, then 1 in IDLE.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - All `sram_*_n`=1, `sram_addr`=0, `sram_dq`=Z.
- **Outputs:** all outputs are registered; the SRAM controls change only on `clk` edges.
- **Latency from accept edge to `resp_valid`:**
  - Byte/half: 2 cycles.
  - Word: 3 cycles.
  - Misaligned: 1 cycle.
- **Throughput:** one request per 3 cycles (byte/half) or 4 cycles (word). `req_ready` is 0 in ACC_LO, ACC_HI and RESP.
- **Reset mid-operation:** the access is aborted with no `resp_valid`. A word store aborted after ACC_LO leaves the low half written.
- **Bus turnaround:** after a store cycle, `dq` returns to Z in the next cycle. No cycle drives `dq` while `oe_n`=0.

## Configuration
`DMEM_CTRL_ALIGN_CHK_EN`:
- **Defined:** a half at an odd address, or a word with addr[1:0]≠0, gives a 1-cycle `resp_err`=1 response with no SRAM access.
- **Undefined:** low address bits are forced to alignment (half: bit 0 cleared; word: bits 1:0 cleared), the access proceeds normally, and `resp_err` is tied 0.

## Structure
- **Shared package `dmem_pkg`:**
  - `size_t` enum (SZ_B, SZ_H, SZ_W).
  - `state_t` enum.
  - `DMEM_ADDR_W`=20.
- **Sub-module `dmem_load_align`:** combinational. Takes the 32-bit buffer, addr[0], size and unsigned flag, and returns `resp_rdata`.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 -> two write cycles (0xBEEF @0x10, 0xDEAD @0x12); `resp_rdata`=0xDEADBEEF, 3 cycles after accept.
- SB 0x80 @0x21, then LB @0x21 and LBU @0x21:
  - Store cycle has only `ub_n`=0.
  - LB gives 0xFFFFFF80; LBU gives 0x00000080.
  - The byte at 0x20 is unchanged.
- SH 0x7FFF @0x30, then LH @0x30 -> 0x00007FFF; SH 0x8001 then LH -> 0xFFFF8001.
- LW @0x12 with `DMEM_CTRL_ALIGN_CHK_EN` defined -> `resp_err`=1 one cycle after accept, `sram_ce_n` held 1. Without the macro -> reads @0x10, `resp_err`=0.
- `rst_n`=0 during ACC_LO of a LW -> no `resp_valid`, all SRAM controls 1 and `dq`=Z next cycle, `req_ready`=1 after release.
- Back-to-back `req_valid` held high with four loads -> exactly one accept per 3/4-cycle window, `req_ready` low while busy, responses in order.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, constants and small helpers for the data-memory controller.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 20;

    // Access size as carried through the controller.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_t;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACC_LO = 2'b01,
        ACC_HI = 2'b10,
        RESP   = 2'b11
    } state_t;

    // Raw CPU size code to size_t; the unused code 11 behaves as a word.
    function automatic size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    // True when the low address bits do not suit the access size.
    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lsbs);
        case (sz)
            SZ_H:    return lsbs[0];
            SZ_W:    return |lsbs;
            default: return 1'b0;
        endcase
    endfunction

    // Clear the low address bits that the access size does not allow.
    function automatic logic [1:0] force_align(input size_t sz, input logic [1:0] lsbs);
        case (sz)
            SZ_H:    return {lsbs[1], 1'b0};
            SZ_W:    return 2'b00;
            default: return lsbs;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/half from the read buffer and extends it to 32 bits.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] buf_data,
    input  logic        addr_lsb,
    input  size_t       size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [7:0] byte_sel;

    // Lane select followed by sign or zero extension.
    always_comb begin
        byte_sel = addr_lsb ? buf_data[15:8] : buf_data[7:0];
        rdata    = buf_data;
        case (size)
            SZ_B:    rdata = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_H:    rdata = {{16{~is_unsigned & buf_data[15]}}, buf_data[15:0]};
            default: rdata = buf_data;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: sequences one CPU byte/half/word load or store into one or two
// 16-bit asynchronous SRAM cycles. All outputs are registered.
// Optional feature macro DMEM_CTRL_ALIGN_CHK_EN: when defined, misaligned
// half/word requests return resp_err without touching the SRAM; otherwise the
// low address bits are forced to alignment and resp_err stays 0.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [15:0]       sram_dq
);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    size_t             size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              lb_n_q, lb_n_d;
    logic              ub_n_q, ub_n_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic              dq_oe_q, dq_oe_d;
    logic [15:0]       dq_out_q, dq_out_d;

    logic [31:0]       load_data;
    logic [ADDR_W-1:0] base_addr;

    // Address bits above the SRAM width carry no meaning here.
    generate
        if (ADDR_W < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[31:ADDR_W];
        end
    endgenerate

    // Next state, request latch and read-buffer capture.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        resp_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = decode_size(req_size);
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    addr_d  = req_addr[ADDR_W-1:0];
`ifdef DMEM_CTRL_ALIGN_CHK_EN
                    if (is_misaligned(size_d, addr_d[1:0])) begin
                        state_d    = RESP;
                        resp_err_d = 1'b1;
                    end else begin
                        state_d = ACC_LO;
                    end
`else
                    addr_d[1:0] = force_align(size_d, addr_d[1:0]);
                    state_d     = ACC_LO;
`endif
                end
            end
            ACC_LO: begin
                if (!we_q) rbuf_d[15:0] = sram_dq;
                state_d = (size_q == SZ_W) ? ACC_HI : RESP;
            end
            ACC_HI: begin
                if (!we_q) rbuf_d[31:16] = sram_dq;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    dmem_load_align u_load_align (
        .buf_data    (rbuf_d),
        .addr_lsb    (addr_d[0]),
        .size        (size_d),
        .is_unsigned (uns_d),
        .rdata       (load_data)
    );

    // Registered outputs for the state being entered, so controls change only on clk edges.
    always_comb begin
        base_addr   = {addr_d[ADDR_W-1:1], 1'b0};
        ce_n_d      = 1'b1;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        sram_addr_d = sram_addr_q;
        dq_oe_d     = 1'b0;
        dq_out_d    = dq_out_q;
        case (state_d)
            ACC_LO: begin
                ce_n_d      = 1'b0;
                we_n_d      = ~we_d;
                oe_n_d      = we_d;
                sram_addr_d = base_addr;
                dq_oe_d     = we_d;
                if (size_d == SZ_B) begin
                    lb_n_d   = addr_d[0];
                    ub_n_d   = ~addr_d[0];
                    dq_out_d = {2{wdata_d[7:0]}};
                end else begin
                    lb_n_d   = 1'b0;
                    ub_n_d   = 1'b0;
                    dq_out_d = wdata_d[15:0];
                end
            end
            ACC_HI: begin
                ce_n_d      = 1'b0;
                we_n_d      = ~we_d;
                oe_n_d      = we_d;
                lb_n_d      = 1'b0;
                ub_n_d      = 1'b0;
                sram_addr_d = base_addr + ADDR_W'(2);
                dq_oe_d     = we_d;
                dq_out_d    = wdata_d[31:16];
            end
            default: ;
        endcase
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        resp_rdata_d = (state_d == RESP && !we_d && !resp_err_d) ? load_data : 32'h0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ce_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            lb_n_q       <= 1'b1;
            ub_n_q       <= 1'b1;
            sram_addr_q  <= '0;
            dq_oe_q      <= 1'b0;
            dq_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ce_n_q       <= ce_n_d;
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
            lb_n_q       <= lb_n_d;
            ub_n_q       <= ub_n_d;
            sram_addr_q  <= sram_addr_d;
            dq_oe_q      <= dq_oe_d;
            dq_out_q     <= dq_out_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_lb_n  = lb_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq    = dq_oe_q ? dq_out_q : 16'hzzzz;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: behavioural SRAM plus a byte-array reference model.
module tb_dmem_ctrl;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          req_ready, resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n;
    logic [AW-1:0] sram_addr;
    wire  [15:0]   sram_dq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .sram_ce_n    (sram_ce_n),
        .sram_we_n    (sram_we_n),
        .sram_oe_n    (sram_oe_n),
        .sram_lb_n    (sram_lb_n),
        .sram_ub_n    (sram_ub_n),
        .sram_addr    (sram_addr),
        .sram_dq      (sram_dq)
    );

    function automatic logic [15:0] init_val(input int k);
        return 16'(k * 40503) ^ 16'h5A5A;
    endfunction

    // ---------------- SRAM device model ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic          lb_n;
        logic          ub_n;
    } wr_t;

    logic [15:0] sram_mem [0:4095];
    bit          init_done = 1'b0;
    wr_t         wr_log[$];
    int          ce_cycles = 0;
    logic        probe_en = 1'b0;
    logic        tb_en;
    logic [15:0] tb_val;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int k = 0; k < 4096; k++) sram_mem[k] <= init_val(k);
            init_done <= 1'b1;
        end
        if (!sram_ce_n) ce_cycles <= ce_cycles + 1;
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) sram_mem[sram_addr[12:1]][7:0]  <= sram_dq[7:0];
            if (!sram_ub_n) sram_mem[sram_addr[12:1]][15:8] <= sram_dq[15:8];
            wr_log.push_back({sram_addr, sram_dq, sram_lb_n, sram_ub_n});
        end
    end

    // SRAM read drive; probe drives 0 so that a stray DUT driver becomes visible.
    always_comb begin
        tb_en  = 1'b0;
        tb_val = 16'h0000;
        if (!sram_ce_n && !sram_oe_n) begin
            tb_en  = 1'b1;
            tb_val = sram_mem[sram_addr[12:1]];
        end else if (probe_en) begin
            tb_en  = 1'b1;
            tb_val = 16'h0000;
        end
    end
    assign sram_dq = tb_en ? tb_val : 16'hzzzz;

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:8191];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
`ifdef DMEM_CTRL_ALIGN_CHK_EN
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [12:0] eff_addr(input logic [31:0] a, input logic [1:0] sz);
        logic [12:0] e;
        e = a[12:0];
`ifndef DMEM_CTRL_ALIGN_CHK_EN
        if (sz == 2'b01) e[0] = 1'b0;
        else if (sz[1]) e[1:0] = 2'b00;
`endif
        return e;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [12:0] e;
        logic [31:0] v;
        int n;
        e = eff_addr(a, sz);
        n = nbytes(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[e + 13'(i)];
        if (!uns && n == 1) v[31:8]  = {24{v[7]}};
        if (!uns && n == 2) v[31:16] = {16{v[15]}};
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [12:0] e;
        e = eff_addr(a, sz);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[e + 13'(i)] = wd[8*i +: 8];
    endtask

    // One request: wait for ready, let it be accepted, count negedges to resp_valid.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
        rd = resp_rdata;
        er = resp_err;
        $display("txn we=%0d size=%0d uns=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
                 we, sz, uns, a, wd, rd, er, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        probe_en = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_err} !== 3'b000) begin
            n_bad++; $display("FAIL reset_handshake: got %b required 000", {req_ready, resp_valid, resp_err});
        end
        n_cmp++;
        if ({sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n} !== 5'b11111) begin
            n_bad++; $display("FAIL reset_sram_ctl: got %b required 11111",
                              {sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n});
        end
        n_cmp++;
        if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %08h required 0", resp_rdata); end
        n_cmp++;
        if (sram_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %05h required 0", sram_addr); end
        n_cmp++;
        if (sram_dq !== 16'h0000) begin n_bad++; $display("FAIL reset_dq_released: got %04h required 0000", sram_dq); end
        probe_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b required 1", req_ready); end
        $display("txn reset released");
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; int n0;
        n0 = wr_log.size();
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        ref_store(32'h10, 2'b10, 32'hDEADBEEF);
        n_cmp++;
        if ({rd, er} !== 33'h0 || lat != 3) begin
            n_bad++; $display("FAIL sw_resp: rdata=%08h err=%b lat=%0d required 0/0/3", rd, er, lat);
        end
        n_cmp++;
        if (wr_log.size() - n0 != 2) begin
            n_bad++; $display("FAIL sw_cycles: got %0d write cycles required 2", wr_log.size() - n0);
        end else begin
            n_cmp++;
            if (wr_log[n0] !== {20'h00010, 16'hBEEF, 2'b00} || wr_log[n0+1] !== {20'h00012, 16'hDEAD, 2'b00}) begin
                n_bad++; $display("FAIL sw_cycle_content: got %h %h required 00010beef0 00012dead0",
                                  wr_log[n0], wr_log[n0+1]);
            end
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 3) begin
            n_bad++; $display("FAIL lw_resp: rdata=%08h err=%b lat=%0d required deadbeef/0/3", rd, er, lat);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat; int n0;
        n0 = wr_log.size();
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000080, rd, er, lat);
        ref_store(32'h21, 2'b00, 32'h80);
        n_cmp++;
        if (wr_log.size() - n0 != 1 || lat != 2) begin
            n_bad++; $display("FAIL sb_cycles: writes=%0d lat=%0d required 1/2", wr_log.size() - n0, lat);
        end else begin
            n_cmp++;
            if (wr_log[n0] !== {20'h00020, 16'h8080, 1'b1, 1'b0}) begin
                n_bad++; $display("FAIL sb_lanes: got %h required 0002080802", wr_log[n0]);
            end
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'hFFFFFF80 || lat != 2) begin
            n_bad++; $display("FAIL lb_signed: rdata=%08h lat=%0d required ffffff80/2", rd, lat);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'h00000080) begin n_bad++; $display("FAIL lbu: rdata=%08h required 00000080", rd); end
        do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, rd, er, lat);
        n_cmp++;
        if (rd !== {24'h0, ref_mem[32]}) begin
            n_bad++; $display("FAIL sb_neighbour: rdata=%08h required %08h", rd, {24'h0, ref_mem[32]});
        end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b01, 1'b0, 32'h30, 32'h00007FFF, rd, er, lat);
        ref_store(32'h30, 2'b01, 32'h7FFF);
        do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'h00007FFF || lat != 2) begin
            n_bad++; $display("FAIL lh_pos: rdata=%08h lat=%0d required 00007fff/2", rd, lat);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h30, 32'h00008001, rd, er, lat);
        ref_store(32'h30, 2'b01, 32'h8001);
        do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_neg: rdata=%08h required ffff8001", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat; int ce0;
        ce0 = ce_cycles;
        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rd, er, lat);
`ifdef DMEM_CTRL_ALIGN_CHK_EN
        n_cmp++;
        if (er !== 1'b1 || lat != 1 || rd !== 32'h0) begin
            n_bad++; $display("FAIL misalign_err: err=%b lat=%0d rdata=%08h required 1/1/0", er, lat, rd);
        end
        n_cmp++;
        if (ce_cycles != ce0) begin
            n_bad++; $display("FAIL misalign_no_sram: ce cycles=%0d required 0", ce_cycles - ce0);
        end
`else
        n_cmp++;
        if (rd !== ref_load(32'h12, 2'b10, 1'b0) || er !== 1'b0 || lat != 3) begin
            n_bad++; $display("FAIL misalign_forced: rdata=%08h err=%b lat=%0d required %08h/0/3",
                              rd, er, lat, ref_load(32'h12, 2'b10, 1'b0));
        end
        n_cmp++;
        if (ce_cycles - ce0 != 2) begin
            n_bad++; $display("FAIL misalign_forced_cycles: ce cycles=%0d required 2", ce_cycles - ce0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int w; int seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if ({sram_ce_n, sram_oe_n} !== 2'b00) begin
            n_bad++; $display("FAIL rmid_acc_lo: ce_n/oe_n=%b required 00", {sram_ce_n, sram_oe_n});
        end
        rst_n = 1'b0;
        probe_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({resp_valid, sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n} !== 6'b011111) begin
            n_bad++; $display("FAIL rmid_ctl: got %b required 011111",
                              {resp_valid, sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n});
        end
        n_cmp++;
        if (sram_dq !== 16'h0000) begin n_bad++; $display("FAIL rmid_dq_released: got %04h required 0000", sram_dq); end
        probe_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b required 1", req_ready); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL rmid_no_resp: resp_valid cycles=%0d required 0", seen); end
        $display("txn reset during ACC_LO of LW @00000040 aborted");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [1:0]  szs [4];
        logic        uss [4];
        logic [31:0] exp_d [4];
        int idx; int got; int cyc; int last;
        szs[0] = 2'b10; szs[1] = 2'b00; szs[2] = 2'b01; szs[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            addrs[i] = {12'($urandom), 7'h0, 13'($urandom)};
            if (szs[i][1]) addrs[i][1:0] = 2'b00;
            else if (szs[i][0]) addrs[i][0] = 1'b0;
            uss[i] = 1'($urandom);
            exp_d[i] = ref_load(addrs[i], szs[i], uss[i]);
        end
        idx = 0; got = 0; cyc = 0; last = 0;
        while (got < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) begin
                n_cmp++;
                if (got >= 4 || resp_rdata !== exp_d[got] || resp_err !== 1'b0) begin
                    n_bad++; $display("FAIL b2b_resp%0d: rdata=%08h err=%b required %08h/0",
                                      got, resp_rdata, resp_err, exp_d[got]);
                end
                got++;
            end
            if (idx < 4) begin
                req_valid = 1'b1; req_we = 1'b0; req_size = szs[idx];
                req_unsigned = uss[idx]; req_addr = addrs[idx];
            end else begin
                req_valid = 1'b0;
            end
            if (req_valid && req_ready) begin
                if (idx > 0) begin
                    n_cmp++;
                    if (cyc - last != (szs[idx-1][1] ? 4 : 3)) begin
                        n_bad++; $display("FAIL b2b_gap%0d: accept gap=%0d required %0d",
                                          idx, cyc - last, szs[idx-1][1] ? 4 : 3);
                    end
                end
                $display("txn b2b accept %0d size=%0d uns=%0d addr=%08h expect=%08h",
                         idx, szs[idx], uss[idx], addrs[idx], exp_d[idx]);
                last = cyc;
                idx++;
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (got != 4) begin n_bad++; $display("FAIL b2b_count: responses=%0d required 4", got); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp_rd; logic er, exp_er, we, uns; logic [1:0] sz; int lat, exp_lat;
        for (int t = 0; t < 60; t++) begin
            we  = 1'($urandom);
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom);
            a   = $urandom;
            a[19:13] = 7'h0;
            wd  = $urandom;
            exp_er  = ref_err(a, sz);
            exp_lat = exp_er ? 1 : (sz[1] ? 3 : 2);
            exp_rd  = (we || exp_er) ? 32'h0 : ref_load(a, sz, uns);
            do_req(we, sz, uns, a, wd, rd, er, lat);
            if (we && !exp_er) ref_store(a, sz, wd);
            n_cmp++;
            if (rd !== exp_rd) begin n_bad++; $display("FAIL rnd%0d_rdata: got %08h required %08h", t, rd, exp_rd); end
            n_cmp++;
            if (er !== exp_er) begin n_bad++; $display("FAIL rnd%0d_err: got %b required %b", t, er, exp_er); end
            n_cmp++;
            if (lat != exp_lat) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d required %0d", t, lat, exp_lat); end
        end
    endtask

    initial begin
        logic [15:0] v;
        for (int k = 0; k < 4096; k++) begin
            v = init_val(k);
            ref_mem[2*k]   = v[7:0];
            ref_mem[2*k+1] = v[15:8];
        end
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
